// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified instruction/data memory
// between the fetch stage (IF) and the load/store stage (DM).
// Each access runs for MEM_LAT memory cycles. The owner then gets a one-cycle
// ack, with read data registered. DM wins a tie because it is the older
// instruction.
// Optional build macro ARB_FAIR_EN: a tie is granted to the requester that
// did not win the last grant, so that back-to-back loads/stores cannot
// starve fetch.
//
// state  | meaning
// IDLE   | no access in flight; sample requests and grant one
// ACCESS | mem_en held; counter runs down to the capture cycle
// RESP   | owner's ack pulses; requests ignored
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;
  // Counter loads LAT-1 so that ACCESS lasts exactly MEM_LAT cycles.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              grant_dm;

`ifdef ARB_FAIR_EN
  logic              last_owner_q, last_owner_d;

  // On a tie, alternate away from whoever was granted last.
  always_comb begin
    grant_dm = dm_req_i & ~(if_req_i & (last_owner_q == OWN_DM));
  end
`else
  // Fixed priority: DM holds the older instruction and wins every tie.
  always_comb begin
    grant_dm = dm_req_i;
  end
`endif

  // Next-state logic for the access sequencer and its datapath registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
`ifdef ARB_FAIR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        mem_en_d = 1'b0;
        if (dm_req_i || if_req_i) begin
          mem_en_d = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = S_ACCESS;
          if (grant_dm) begin
            owner_d     = OWN_DM;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            // Fetch is read-only; leave the write data register alone.
            owner_d    = OWN_IF;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end
`ifdef ARB_FAIR_EN
          last_owner_d = grant_dm ? OWN_DM : OWN_IF;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end else begin
            if (!mem_we_q) dm_rdata_d = mem_rdata_i;
            dm_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
`ifdef ARB_FAIR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
`ifdef ARB_FAIR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  // Stall covers the whole wait, including cycles spent queued behind the
  // other requester; it falls in the ack cycle itself.
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 aux).
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall;

  logic        if_req1 = 1'b0;
  logic [31:0] if_addr1 = '0;
  logic        dm_req1 = 1'b0, dm_we1 = 1'b0;
  logic [31:0] dm_addr1 = '0, dm_wdata1 = '0;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ack1, dm_ack1, mem_en1, mem_we1, stall1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(stall));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_rdata_o(if_rdata1), .if_ack_o(if_ack1),
    .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
    .dm_rdata_o(dm_rdata1), .dm_ack_o(dm_ack1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
    .mem_rdata_i(mem_rdata1), .stall_o(stall1));

  // Device memory seen by the DUT (256 words, indexed by addr[9:2]).
  logic [31:0] dev_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) dev_mem[pl_idx] <= pl_data;
    else if (mem_en && mem_we) dev_mem[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata  = mem_en ? dev_mem[mem_addr[9:2]] : 32'h0;
  assign mem_rdata1 = mem_en1 ? ~mem_addr1 : 32'h0;

  // Reference model state: expected memory contents and registered read data.
  logic [31:0] shadow [256];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
`ifdef ARB_FAIR_EN
  bit model_last_dm = 1'b0;
`endif

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One arbitration round starting in IDLE: requests raised at cycle 0, held
  // until their predicted ack, then every output checked cycle by cycle.
  task automatic run_group(input bit do_if, input bit do_dm, input bit we,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input bit scramble);
    int t_if_g, t_dm_g, t_if_a, t_dm_a, last_c;
    bit first_dm, en_if, en_dm, exp_stall;
`ifdef ARB_FAIR_EN
    first_dm = do_dm && (!do_if || !model_last_dm);
`else
    first_dm = do_dm;
`endif
    t_if_g = -100; t_dm_g = -100;
    if (first_dm) begin
      t_dm_g = 0;
      if (do_if) t_if_g = LAT + 2;
    end else begin
      t_if_g = 0;
      if (do_dm) t_dm_g = LAT + 2;
    end
    t_if_a = t_if_g + LAT + 1;
    t_dm_a = t_dm_g + LAT + 1;
    last_c = (do_if && t_if_a > t_dm_a) || !do_dm ? t_if_a : t_dm_a;
    // Memory effects in grant order.
    for (int k = 0; k < 2; k++) begin
      if ((k == 0) == first_dm) begin
        if (do_dm) begin
          if (we) shadow[da[9:2]] = wd;
          else exp_dm_rdata = shadow[da[9:2]];
`ifdef ARB_FAIR_EN
          model_last_dm = 1'b1;
`endif
        end
      end else if (do_if) begin
        exp_if_rdata = shadow[ia[9:2]];
`ifdef ARB_FAIR_EN
        model_last_dm = 1'b0;
`endif
      end
    end
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      rst_n    = 1'b1;
      if_req   = do_if && c <= t_if_a;
      dm_req   = do_dm && c <= t_dm_a;
      if_addr  = (scramble && c > t_if_g) ? $urandom : ia;
      dm_addr  = (scramble && c > t_dm_g) ? $urandom : da;
      dm_wdata = (scramble && c > t_dm_g) ? $urandom : wd;
      dm_we    = (scramble && c > t_dm_g) ? 1'($urandom) : we;
      @(negedge clk);
      en_if = do_if && c >= t_if_g + 1 && c <= t_if_g + LAT;
      en_dm = do_dm && c >= t_dm_g + 1 && c <= t_dm_g + LAT;
      exp_stall = (if_req && c != t_if_a) || (dm_req && c != t_dm_a);
      chk1("mem_en", mem_en, en_if | en_dm);
      chk1("if_ack", if_ack, do_if && c == t_if_a);
      chk1("dm_ack", dm_ack, do_dm && c == t_dm_a);
      chk1("ack_excl", if_ack & dm_ack, 1'b0);
      chk1("stall", stall, exp_stall);
      if (en_if) begin
        chk32("if_mem_addr", mem_addr, ia);
        chk1("if_mem_we", mem_we, 1'b0);
      end
      if (en_dm) begin
        chk32("dm_mem_addr", mem_addr, da);
        chk1("dm_mem_we", mem_we, we);
        if (we) chk32("dm_mem_wdata", mem_wdata, wd);
      end
      if (!en_if && !en_dm) chk1("mem_we_idle", mem_we, 1'b0);
      if (do_if && c == t_if_a) chk32("if_rdata", if_rdata, exp_if_rdata);
      if (do_dm && c == t_dm_a) chk32("dm_rdata", dm_rdata, exp_dm_rdata);
    end
  endtask

  initial begin
    int ack_cyc [3];
    logic [31:0] a, d;
    // Preload memory and model while the DUTs sit in reset.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      d = $urandom;
      if (i == 4) d = 32'h00A00093;
      shadow[i] = d;
      pl_en = 1'b1; pl_idx = 8'(i); pl_data = d;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;

    // Reset held 3 cycles with a pending fetch.
    if_req = 1'b1; if_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_dm_ack", dm_ack, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk32("rst_if_rdata", if_rdata, 32'h0);
      chk32("rst_dm_rdata", dm_rdata, 32'h0);
    end

    // Single fetch at 0x10 right out of reset.
    run_group(1, 0, 0, 32'h10, 32'h0, 32'h0, 0);
    chk32("fetch_0x10", if_rdata, 32'h00A00093);
    // Store 0xDEADBEEF to 0x40; dm_rdata must remain at reset value.
    run_group(0, 1, 1, 32'h0, 32'h40, 32'hDEADBEEF, 0);
    chk32("store_dm_rdata_kept", dm_rdata, 32'h0);
    // Contention: lw 0x44 against fetch of 0x40 (sees the stored word).
    run_group(1, 1, 0, 32'h40, 32'h44, 32'h0, 0);
    chk32("fetch_after_store", if_rdata, 32'hDEADBEEF);
    // Contention again, with owner inputs changing mid-access.
    run_group(1, 1, 1, 32'h80, 32'h84, 32'h12345678, 1);

    // Randomized rounds.
    for (int n = 0; n < 40; n++) begin
      bit di, dd;
      di = 1'($urandom); dd = 1'($urandom);
      if (!di && !dd) di = 1'b1;
      run_group(di, dd, 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
    end

    // Reset during the ACCESS phase of a store.
    a = 32'h0000_01C0; d = 32'hCAFEF00D;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = a; dm_wdata = d; if_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("mid_pre_mem_we", mem_we, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chk1("mid_mem_en", mem_en, 1'b0);
    chk1("mid_mem_we", mem_we, 1'b0);
    chk1("mid_dm_ack", dm_ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("mid_no_ack", dm_ack, 1'b0);
      chk1("mid_idle_en", mem_en, 1'b0);
    end
    // The write strobe reached memory for one edge before the reset.
    shadow[a[9:2]] = d;
    exp_if_rdata = '0; exp_dm_rdata = '0;
`ifdef ARB_FAIR_EN
    model_last_dm = 1'b0;
`endif
    // Immediate grant afterwards confirms the arbiter is back in IDLE.
    run_group(1, 0, 0, a, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;

    // MEM_LAT=1 back-to-back fetches at 0x0, 0x4, 0x8.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c <= 2; c++) begin
        @(posedge clk); #1;
        if_req1 = 1'b1; if_addr1 = 32'(4 * k);
        @(negedge clk);
        chk1("l1_mem_en", mem_en1, c == 1);
        chk1("l1_if_ack", if_ack1, c == 2);
        chk1("l1_stall", stall1, c != 2);
        if (c == 1) chk32("l1_mem_addr", mem_addr1, 32'(4 * k));
        if (c == 2) begin
          chk32("l1_if_rdata", if_rdata1, ~32'(4 * k));
          ack_cyc[k] = cyc;
        end
      end
    end
    @(posedge clk); #1;
    if_req1 = 1'b0;
    @(negedge clk);
    chk32("l1_ack_gap_a", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    chk32("l1_ack_gap_b", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
    chk1("l1_dm_ack", dm_ack1, 1'b0);
    chk1("l1_mem_we", mem_we1, 1'b0);
    chk32("l1_dm_rdata", dm_rdata1, 32'h0);
    chk32("l1_mem_wdata", mem_wdata1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the fetch stage (IF) and the load/store stage (DM) of the RISC-V core.
- Sequences each access through a fixed-latency memory cycle.
- Returns read data with a one-cycle ack pulse.
- Drives the pipeline `stall` input of the control unit while any request is outstanding.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch read request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; registered; valid in the if_ack cycle.
- if_ack  out  1  one-cycle pulse, fetch complete.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store (sw), 0 = load (lw).
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; registered; valid in the dm_ack cycle.
- dm_ack  out  1  one-cycle pulse, data access complete (loads and stores).
- mem_en  out  1  memory enable; registered.
- mem_we  out  1  memory write enable; registered.
- mem_addr  out  ADDR_W  memory address; registered.
- mem_wdata  out  DATA_W  memory write data; registered.
- mem_rdata  in  DATA_W  memory read data; valid on the last mem_en cycle.
- stall  out  1  combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack).

Behaviour:
- Single clock. Synchronous active-low reset (rst_n sampled on rising clk).
- Reset values: state = IDLE; mem_en, mem_we, if_ack, dm_ack = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; latency counter = 0; owner = IF.
- FSM states: IDLE, ACCESS, RESP.
- IDLE with dm_req = 1:
  - Grant DM; DM has priority because it is the older instruction.
  - Latch dm_addr, dm_we, dm_wdata into the mem_* registers; set mem_en = 1; counter = MEM_LAT-1; go to ACCESS.
- IDLE with only if_req = 1: grant IF the same way, with mem_we = 0 and mem_wdata unchanged.
- IDLE with no request: stay in IDLE; mem_en = 0.
- ACCESS:
  - mem_en held high; mem_addr, mem_we and mem_wdata stable.
  - Counter decrements each cycle.
  - On counter == 0: capture mem_rdata into the owner's rdata register (loads and fetches only; dm_rdata is unchanged for stores); deassert mem_en and mem_we; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle; go to IDLE.
  - Requests are not sampled in RESP.
  - The requester drops req or presents a new address in the cycle after ack.
- Timing: request first seen in IDLE at cycle t → mem_en high cycles t+1 .. t+MEM_LAT → ack at t+MEM_LAT+1.
  - Earliest next grant: IDLE at t+MEM_LAT+2.
  - With MEM_LAT=2: 4-cycle period per access; an uncontended lw occupies 3 stall cycles.
- MEM_LAT = 1: ACCESS lasts one cycle (counter loads 0).
- Simultaneous if_req and dm_req: DM served first. IF stays pending, stall stays high, and IF is granted on the next IDLE.
- Request deasserted mid-transaction (protocol violation): the access completes; ack still pulses; the write is still performed.
- Owner's address or data changing mid-transaction: ignored, because values were latched at grant.
- Reset asserted mid-ACCESS: the next edge forces IDLE with mem_en/mem_we = 0; the transaction is abandoned with no ack.
- Only one ack may be high in any cycle. if_ack and dm_ack are never both 1.
- No address translation or alignment checking; addresses pass through unchanged.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - Add a 1-bit last_owner register (reset = IF).
  - When both requests are seen in IDLE, grant the requester that was not last_owner. last_owner updates on every grant.
  - Single-requester behaviour is unchanged.
  - IF can never be starved by consecutive loads/stores.
- Undefined: fixed DM-over-IF priority as described in Behaviour; no last_owner register is synthesised.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with if_req = 1 → all outputs 0, no mem_en; first mem_en appears 1 cycle after rst_n rises.
- Single fetch, MEM_LAT=2: if_req = 1, if_addr = 0x00000010, memory returns 0x00A00093 → mem_en high 2 cycles with mem_addr = 0x10; if_ack at cycle 3 with if_rdata = 0x00A00093; stall high cycles 0–2, low at 3.
- Store: dm_req = 1, dm_we = 1, dm_addr = 0x00000040, dm_wdata = 0xDEADBEEF → mem_we = 1 for exactly 2 cycles with those values; dm_ack pulses once; dm_rdata unchanged.
- Contention: if_req and dm_req (lw at 0x44) raised in the same cycle → DM acked first; IF mem_en begins 2 cycles after dm_ack; never two acks in one cycle. With ARB_FAIR_EN and last_owner = DM, IF is granted first.
- MEM_LAT=1 back-to-back fetches at 0x0, 0x4, 0x8 → acks every 3 cycles with matching rdata.
- Reset mid-ACCESS of a store → mem_en/mem_we = 0 at the next edge; no dm_ack; FSM in IDLE.
